// File: rtl/acc_reduce.sv
// Accumulate-and-reduce stage: sums num_reads_per_iter masked products per iteration
// and emits one ACC_WIDTH partial sum per iteration, fed through a 4-entry input FIFO.
module acc_reduce #(
    parameter int GROUP_SIZE             = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int ACC_WIDTH              = 32,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [2*DATA_WIDTH+GROUP_SIZE-1:0] data_in,
    input  logic                              valid_in,
    output logic                              avail_out,
    output logic [ACC_WIDTH-1:0]              data_out,
    output logic                              valid_out,
    input  logic                              avail_in,
    output logic                              busy
);

    localparam int PROD_WIDTH  = 2*DATA_WIDTH;
    localparam int INPUT_WIDTH = PROD_WIDTH + GROUP_SIZE;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t state, next_state;

    logic [INPUT_WIDTH-1:0]            fifo_mem [4];
    logic [1:0]                        wr_ptr, rd_ptr;
    logic [2:0]                        count;
    logic                              full, empty, push, pop;

    logic [LOG_MAX_ITERS-1:0]          iters_cnt;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_cnt, reads_cfg;
    logic [ACC_WIDTH-1:0]              acc_p0, result_p1, term_p0;
    logic                              cfg_ok, last_read, last_iter;

    // Any set zero-info bit kills the product; otherwise zero-extend to the accumulator.
    function automatic logic [ACC_WIDTH-1:0] select_term(input logic [INPUT_WIDTH-1:0] w);
        logic [ACC_WIDTH-1:0] t;
        t = '0;
        if (w[INPUT_WIDTH-1:PROD_WIDTH] == '0)
            t[PROD_WIDTH-1:0] = w[PROD_WIDTH-1:0];
        return t;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b);
        return a + b;
    endfunction

    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign avail_out = (count < 3'd3);
    assign push      = valid_in & ~full;
    // A configure cycle never pops, so queued words survive an abort untouched.
    assign pop       = (state == ACCUM) & ~empty & ~configure;

    assign cfg_ok    = (num_iters != '0) && (num_reads_per_iter != '0);
    assign last_read = (reads_cnt == LOG_MAX_READS_PER_ITER'(1));
    assign last_iter = (iters_cnt == LOG_MAX_ITERS'(1));
    assign term_p0   = select_term(fifo_mem[rd_ptr]);

    assign busy      = (state != IDLE);
    assign valid_out = (state == OUT) & avail_in & ~configure;
    assign data_out  = result_p1;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (configure) begin
            next_state = cfg_ok ? ACCUM : IDLE;
        end else begin
            case (state)
                ACCUM: if (pop && last_read) next_state = OUT;
                OUT:   if (avail_in) next_state = last_iter ? IDLE : ACCUM;
                default: next_state = state;
            endcase
        end
    end

    // Stage p0: running sum; stage p1: per-iteration result held for downstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            iters_cnt <= '0;
            reads_cnt <= '0;
            reads_cfg <= '0;
            acc_p0    <= '0;
            result_p1 <= '0;
        end else if (configure) begin
            acc_p0 <= '0;
            if (cfg_ok) begin
                iters_cnt <= num_iters;
                reads_cnt <= num_reads_per_iter;
                reads_cfg <= num_reads_per_iter;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (pop) begin
                        if (last_read) begin
                            result_p1 <= wrap_add(acc_p0, term_p0);
                            acc_p0    <= '0;
                            reads_cnt <= reads_cfg;
                        end else begin
                            acc_p0    <= wrap_add(acc_p0, term_p0);
                            reads_cnt <= reads_cnt - LOG_MAX_READS_PER_ITER'(1);
                        end
                    end
                end
                OUT: begin
                    if (avail_in && !last_iter)
                        iters_cnt <= iters_cnt - LOG_MAX_ITERS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
